// File: rtl/instr_loader.sv
// instr_loader: feeds an instruction buffer from a valid/ready source stream.
// Each accepted word is placed in the next sequential slot. A load ends on a
// zero terminator word or when every slot has been written.
module instr_loader #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16,
    localparam int IW             = $clog2(bs)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic [Instr_word_size-1:0] in_data,
    output logic                       in_ready,
    output logic [IW-1:0]              buffer_index,
    output logic [Instr_word_size-1:0] instr_word,
    output logic                       load_done,
    output logic                       load_full,
    output logic [IW:0]                instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_SLOT = IW'(bs - 1);

    state_t                     r_state;
    logic [IW-1:0]              r_wr_ptr;
    logic [IW-1:0]              r_buffer_index;
    logic [Instr_word_size-1:0] r_instr_word;
    logic                       r_load_done;
    logic                       r_load_full;
    logic [IW:0]                r_instr_count;

    logic w_loading;
    logic w_accept;
    logic w_term;
    logic w_last;

    // Handshake qualifiers; ready depends on the state register alone.
    always_comb begin
        w_loading = (r_state == S_LOAD);
        w_accept  = in_valid && w_loading;
        w_term    = (in_data == '0);
        w_last    = (r_wr_ptr == LAST_SLOT);
    end

    // Load sequencer: state, slot pointer and all registered buffer-side outputs.
    // The index/word pair only moves on an accept, so the buffer's every-cycle
    // write simply rewrites the same slot while the stream is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_buffer_index <= '0;
            r_instr_word   <= '0;
            r_load_done    <= 1'b0;
            r_load_full    <= 1'b0;
            r_instr_count  <= '0;
        end else if (abort) begin
            // Cancel wins over accept and load_req; the data pair and count stay put.
            r_state     <= S_IDLE;
            r_load_done <= 1'b0;
            r_load_full <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_req) begin
                        r_state       <= S_LOAD;
                        r_wr_ptr      <= '0;
                        r_instr_count <= '0;
                        r_load_done   <= 1'b0;
                        r_load_full   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_instr_word   <= in_data;
                        r_buffer_index <= r_wr_ptr;
                        r_wr_ptr       <= r_wr_ptr + 1'b1;
                        r_instr_count  <= r_instr_count + 1'b1;
                        if (w_term) begin
                            // The zero word is still written: it starts the buffer.
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                        end else if (w_last) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_load_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = w_loading;
    assign buffer_index = r_buffer_index;
    assign instr_word   = r_instr_word;
    assign load_done    = r_load_done;
    assign load_full    = r_load_full;
    assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (defaults: 32-bit words, 16 slots).
module tb_instr_loader;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int IW = $clog2(BS);

    logic          clk;
    logic          rst;
    logic          load_req;
    logic          abort;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [IW-1:0] buffer_index;
    logic [W-1:0]  instr_word;
    logic          load_done;
    logic          load_full;
    logic [IW:0]   instr_count;

    int n_checks;
    int n_pass;

    instr_loader #(.Instr_word_size(W), .bs(BS)) dut (
        .clk(clk),
        .rst(rst),
        .load_req(load_req),
        .abort(abort),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .buffer_index(buffer_index),
        .instr_word(instr_word),
        .load_done(load_done),
        .load_full(load_full),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          lr;
        logic          ab;
        logic          vld;
        logic [W-1:0]  dat;
        logic          e_rdy;
        logic [IW-1:0] e_idx;
        logic [W-1:0]  e_word;
        logic          e_done;
        logic          e_full;
        logic [IW:0]   e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic [IW-1:0] idx,
                             input logic [W-1:0] word, input logic done, input logic full,
                             input logic [IW:0] cnt);
        check({tag, ".rdy"},  32'(in_ready),     32'(rdy));
        check({tag, ".idx"},  32'(buffer_index), 32'(idx));
        check({tag, ".word"}, instr_word,        word);
        check({tag, ".done"}, 32'(load_done),    32'(done));
        check({tag, ".full"}, 32'(load_full),    32'(full));
        check({tag, ".cnt"},  32'(instr_count),  32'(cnt));
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic cyc(input logic lr, input logic ab, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        load_req = lr;
        abort    = ab;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        load_req = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        //            lr    ab    vld   data   rdy   idx    word   done  full  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd0, 32'h0,  1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 4'd0, 32'h11, 1'b0, 1'b0, 5'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b1, 4'd1, 32'h22, 1'b0, 1'b0, 5'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 4'd2, 32'h33, 1'b0, 1'b0, 5'd3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 4'd3, 32'h0,  1'b1, 1'b0, 5'd4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 4'd3, 32'h0,  1'b1, 1'b0, 5'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 4'd3, 32'h0,  1'b0, 1'b0, 5'd4};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 4'd3, 32'h0,  1'b0, 1'b0, 5'd4};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd3, 32'h0,  1'b0, 1'b0, 5'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b1, 4'd0, 32'hA1, 1'b0, 1'b0, 5'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hA2, 1'b1, 4'd1, 32'hA2, 1'b0, 1'b0, 5'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd1, 32'hA2, 1'b0, 1'b0, 5'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd3};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd3};

        // Reset state while reset is held.
        #3;
        check_all("reset", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven: terminated load, ignored inputs, abort priority.
        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].lr, vecs[i].ab, vecs[i].vld, vecs[i].dat);
            check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_idx, vecs[i].e_word,
                      vecs[i].e_done, vecs[i].e_full, vecs[i].e_cnt);
        end

        // Full load: words 1..16 with random valid gaps; outputs hold during gaps.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("full.start", 1'b1, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= BS; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 32'hDEAD);
                if (k == 1) check_all($sformatf("full.gap%0d", k), 1'b1, 4'd2, 32'hA3, 1'b0, 1'b0, 5'd0);
                else check_all($sformatf("full.gap%0d", k), 1'b1, 4'(k - 2), 32'(k - 1), 1'b0, 1'b0, 5'(k - 1));
            end
            cyc(1'b0, 1'b0, 1'b1, 32'(k));
            if (k < BS) check_all($sformatf("full.w%0d", k), 1'b1, 4'(k - 1), 32'(k), 1'b0, 1'b0, 5'(k));
            else check_all("full.last", 1'b0, 4'd15, 32'd16, 1'b1, 1'b1, 5'd16);
        end
        cyc(1'b0, 1'b0, 1'b1, 32'd17);
        check_all("full.17th", 1'b0, 4'd15, 32'd16, 1'b1, 1'b1, 5'd16);

        // Zero word in the last slot counts as a terminator, not a full load.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("z15.start", 1'b1, 4'd15, 32'd16, 1'b0, 1'b0, 5'd0);
        for (int k = 1; k < BS; k++) cyc(1'b0, 1'b0, 1'b1, 32'(k + 32'h100));
        check_all("z15.w15", 1'b1, 4'd14, 32'h10F, 1'b0, 1'b0, 5'd15);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check_all("z15.term", 1'b0, 4'd15, 32'h0, 1'b1, 1'b0, 5'd16);

        // Asynchronous reset mid-load after 5 words.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b0, 1'b1, 32'(k + 32'h200));
        check_all("ar.pre", 1'b1, 4'd4, 32'h205, 1'b0, 1'b0, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all("ar.async", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("ar.restart", 1'b1, 4'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'hB1);
        check_all("ar.w1", 1'b1, 4'd0, 32'hB1, 1'b0, 1'b0, 5'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'hB2);
        check_all("ar.w2", 1'b1, 4'd1, 32'hB2, 1'b0, 1'b0, 5'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Upstream feeder for the instruction buffer. It accepts instruction words from a valid/ready source stream, assigns each one a sequential slot index, and drives the buffer's write word and index pair. A load ends on a zero terminator word or when all `bs` slots are written. Completion is reported with a count of loaded words.

## Interface
- `Instr_word_size`, default 32: instruction word width.
- `bs`, default 16: buffer depth in slots; power of two, at least 2. IW = $clog2(bs).

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_req`  in  1  one-cycle request to start a new load.
- `abort`  in  1  synchronous cancel of a load in progress.
- `in_valid`  in  1  source word valid.
- `in_data`  in  Instr_word_size  source word.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `buffer_index`  out  IW  slot index; connects to the buffer's index input.
- `instr_word`  out  Instr_word_size  word to write; connects to the buffer's data input.
- `load_done`  out  1  load finished; held high until the next load or abort.
- `load_full`  out  1  load ended because all `bs` slots were filled without a terminator.
- `instr_count`  out  IW+1  number of words accepted in the current or last load, terminator included.

## Operation
- The buffer writes `instr_word` into slot `buffer_index` on every clock. The loader therefore holds both outputs stable whenever no word is being delivered. A held pair rewrites the same value into the same slot, which has no effect.
- States are IDLE, LOAD and DONE. Reset enters IDLE.
- `in_ready` = (state == LOAD). It is decoded from the state register only.
- A handshake ("accept") occurs when `in_valid` and `in_ready` are both high.
- IDLE:
  - `load_req` → LOAD.
  - On that transition: `wr_ptr` ← 0, `instr_count` ← 0, `load_done` ← 0, `load_full` ← 0.
- LOAD, on each accept:
  - `instr_word` ← `in_data`.
  - `buffer_index` ← `wr_ptr`.
  - `wr_ptr` ← `wr_ptr` + 1, wrapping modulo `bs`.
  - `instr_count` ← `instr_count` + 1.
  - If `in_data` == 0 → DONE with `load_done` ← 1. The zero word is still written; it is the buffer's start trigger.
  - Else if this was slot `bs`-1 → DONE with `load_done` ← 1 and `load_full` ← 1.
  - A zero word arriving in slot `bs`-1 counts as a terminator: `load_full` = 0.
- DONE:
  - Outputs are held.
  - `load_req` → LOAD, with the same initialisation as from IDLE.
- `abort`, in any state:
  - Next state IDLE; `load_done` ← 0, `load_full` ← 0.
  - `instr_word`, `buffer_index` and `instr_count` are held.
  - `abort` has priority over an accept and over `load_req` in the same cycle. A word offered in that cycle is not consumed and is not counted.
- Ignored inputs:
  - `load_req` while in LOAD.
  - `in_valid` outside LOAD; `in_data` is not sampled.
- `instr_count` never exceeds `bs`.

## Timing
- All outputs are registered except `in_ready`, which comes from state.
- Reset values:
  - state IDLE; `in_ready` 0.
  - `instr_word` 0; `buffer_index` 0.
  - `load_done` 0; `load_full` 0.
  - `instr_count` 0; `wr_ptr` 0.
- `load_req` sampled at edge N: `in_ready` is high from cycle N+1.
- Accept at edge N: `instr_word`, `buffer_index` and `instr_count` are updated from cycle N+1. The buffer captures the word at edge N+1, so store latency is two edges after the source handshake.
- Throughput: one word per cycle while `in_valid` stays high.
- Final accept at edge N: `in_ready` is low and `load_done` is high from cycle N+1. No further word is accepted after the terminator or the `bs`-th word.
- Asserting reset mid-load returns every output to its reset value immediately, without waiting for a clock edge. Words already written to the buffer are not this block's concern.

## Test plan
- Reset, then `load_req`, then words 0x11, 0x22, 0x33, 0x0 back-to-back → (`buffer_index`, `instr_word`) sequence (0,0x11), (1,0x22), (2,0x33), (3,0x0) on consecutive cycles. `load_done`=1, `load_full`=0, `instr_count`=4, `in_ready`=0 after the last accept.
- With `bs`=16, deliver 16 nonzero words 1..16 with random `in_valid` gaps → indices 0..15 each written exactly once. Outputs hold during gaps. `load_full`=1, `instr_count`=16, and a 17th offered word is not accepted.
- Word 0 delivered in slot 15 → `load_done`=1, `load_full`=0, `instr_count`=16.
- `abort` asserted in the same cycle as an accept of 0x55 after 3 words → state IDLE; `instr_count` stays 3; `instr_word` is not 0x55; `load_done`=0.
- Reset asserted mid-load after 5 words → all outputs return to reset values asynchronously. A following `load_req` restarts at index 0 with count 0.
- `load_req` pulsed while in LOAD, and `in_valid` driven high while in IDLE → no state change, and no output changes.
